// File: rtl/rtr_flags_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : rtr_flags_tracker
//  Description : Per-(output port, packet class) flag storage for the router
//                output stage. Accepts overwrite or set/clear updates, serves
//                NUM_LOOKUPS independent registered lookups with same-cycle
//                update bypass, exports the whole stored array and raises a
//                sticky error on malformed one-hot selects.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            clock, all state changes on the rising edge
//    reset          asynchronous active-low reset
//    upd_*          update request: one-hot port/class, data to write/set
//    clr_*          clear request (set/clear mode only): one-hot port/class,
//                   bits to clear
//    lkp_valid      per-channel lookup request
//    lkp_sel_mc     per-channel one-hot message class
//    lkp_route_op   per-channel one-hot output port
//    lkp_route_orc  per-channel one-hot resource class
//    flags          per-channel registered lookup result
//    flags_valid    per-channel registered copy of lkp_valid
//    flags_op_opc   stored flag array (entry e at [e*WIDTH +: WIDTH])
//    error          sticky malformed-select indicator
// ============================================================================
module rtr_flags_tracker #(
    parameter int                 NUM_MESSAGE_CLASSES  = 2,
    parameter int                 NUM_RESOURCE_CLASSES = 2,
    parameter int                 NUM_PORTS            = 5,
    parameter int                 WIDTH                = 1,
    parameter int                 NUM_LOOKUPS          = 2,
    parameter int                 UPDATE_MODE          = 0,
    parameter logic [WIDTH-1:0]   RESET_VALUE          = '0
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            upd_valid,
    input  logic [0:NUM_PORTS-1]                            upd_op,
    input  logic [0:NUM_MESSAGE_CLASSES*NUM_RESOURCE_CLASSES-1] upd_opc,
    input  logic [WIDTH-1:0]                                upd_data,
    input  logic                                            clr_valid,
    input  logic [0:NUM_PORTS-1]                            clr_op,
    input  logic [0:NUM_MESSAGE_CLASSES*NUM_RESOURCE_CLASSES-1] clr_opc,
    input  logic [WIDTH-1:0]                                clr_data,
    input  logic [0:NUM_LOOKUPS-1]                          lkp_valid,
    input  logic [0:NUM_LOOKUPS*NUM_MESSAGE_CLASSES-1]      lkp_sel_mc,
    input  logic [0:NUM_LOOKUPS*NUM_PORTS-1]                lkp_route_op,
    input  logic [0:NUM_LOOKUPS*NUM_RESOURCE_CLASSES-1]     lkp_route_orc,
    output logic [0:NUM_LOOKUPS*WIDTH-1]                    flags,
    output logic [0:NUM_LOOKUPS-1]                          flags_valid,
    output logic [0:NUM_PORTS*NUM_MESSAGE_CLASSES*NUM_RESOURCE_CLASSES*WIDTH-1] flags_op_opc,
    output logic                                            error
);

    localparam int NMC         = NUM_MESSAGE_CLASSES;
    localparam int NRC         = NUM_RESOURCE_CLASSES;
    localparam int NPC         = NMC * NRC;
    localparam int NUM_ENTRIES = NUM_PORTS * NPC;

    logic [WIDTH-1:0]       r_mem  [NUM_ENTRIES];
    logic [WIDTH-1:0]       w_next [NUM_ENTRIES];
    logic [0:NUM_LOOKUPS-1] r_flags_valid;
    logic [0:NUM_LOOKUPS-1] w_lkp_bad;
    logic                   w_upd_bad;
    logic                   w_clr_bad;
    logic                   r_error;

    // ------------------------------------------------------------------
    // Storage: one register per entry, next-state also feeds the lookup
    // bypass so a same-cycle write is visible to readers.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        for (genvar c = 0; c < NPC; c++) begin : g_pc
            localparam int ENTRY_IDX = p * NPC + c;

            logic w_hit_u;
            assign w_hit_u = upd_valid & upd_op[p] & upd_opc[c];

            if (UPDATE_MODE == 0) begin : g_ovr
                assign w_next[ENTRY_IDX] = w_hit_u ? upd_data : r_mem[ENTRY_IDX];
            end else begin : g_setclr
                logic w_hit_c;
                assign w_hit_c = clr_valid & clr_op[p] & clr_opc[c];
                // Clear is applied first and the set ORed afterwards, so a
                // bit that is both set and cleared ends up set.
                assign w_next[ENTRY_IDX] =
                    (r_mem[ENTRY_IDX] & ~(w_hit_c ? clr_data : {WIDTH{1'b0}})) |
                    (w_hit_u ? upd_data : {WIDTH{1'b0}});
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_mem[ENTRY_IDX] <= RESET_VALUE;
                end else begin
                    r_mem[ENTRY_IDX] <= w_next[ENTRY_IDX];
                end
            end

            assign flags_op_opc[ENTRY_IDX*WIDTH +: WIDTH] = r_mem[ENTRY_IDX];
        end
    end

    // ------------------------------------------------------------------
    // Lookup channels: AND-OR decode over the bypassed next-state values.
    // A malformed select ORs every decoded entry; a zero select gives 0.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_LOOKUPS; k++) begin : g_lkp
        logic [WIDTH-1:0] w_rd;
        logic [WIDTH-1:0] r_flags;

        always_comb begin
            w_rd = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int m = 0; m < NMC; m++) begin
                    for (int r = 0; r < NRC; r++) begin
                        if (lkp_route_op[k*NUM_PORTS + p] &&
                            lkp_sel_mc[k*NMC + m] &&
                            lkp_route_orc[k*NRC + r]) begin
                            w_rd = w_rd | w_next[p*NPC + m*NRC + r];
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_flags <= '0;
            end else if (lkp_valid[k]) begin
                r_flags <= w_rd;
            end
        end

        assign flags[k*WIDTH +: WIDTH] = r_flags;

        assign w_lkp_bad[k] = lkp_valid[k] &
            ~($onehot(lkp_sel_mc[k*NMC +: NMC]) &
              $onehot(lkp_route_op[k*NUM_PORTS +: NUM_PORTS]) &
              $onehot(lkp_route_orc[k*NRC +: NRC]));
    end

    // ------------------------------------------------------------------
    // Malformed-select detection (only valid requests are inspected)
    // ------------------------------------------------------------------
    assign w_upd_bad = upd_valid & ~($onehot(upd_op) & $onehot(upd_opc));

    if (UPDATE_MODE == 1) begin : g_clr_chk
        assign w_clr_bad = clr_valid & ~($onehot(clr_op) & $onehot(clr_opc));
    end else begin : g_clr_sink
        // Clear port is inert in overwrite mode.
        logic w_unused_clr;
        assign w_unused_clr = ^{clr_valid, clr_op, clr_opc, clr_data};
        assign w_clr_bad    = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags_valid <= '0;
            r_error       <= 1'b0;
        end else begin
            r_flags_valid <= lkp_valid;
            r_error       <= r_error | w_upd_bad | w_clr_bad | (|w_lkp_bad);
        end
    end

    assign flags_valid = r_flags_valid;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: doc/rtr_flags_tracker.md
# rtr_flags_tracker

Stateful, multi-lookup successor to the combinational per-port/per-class flags selector in the router output stage. Holds one `width`-bit flag field per (output port, packet class) entry and accepts set/overwrite and clear updates. Serves `num_lookups` independent requesters (e.g. VC allocator and switch allocator), each getting a registered lookup with same-cycle update bypass. Also exports the full flag array and detects malformed one-hot selects.

## Interface
- num_message_classes, 2, message classes per port
- num_resource_classes, 2, resource classes per message class
- num_ports, 5, router output ports
- width, 1, bits per flag entry
- num_lookups, 2, independent lookup channels
- update_mode, 0, 0 = overwrite (`upd_data` replaces entry); 1 = set/clear (`upd_data` ORed in, `clr_data` cleared)
- reset_value, 0, `width`-bit value loaded into every entry at reset
- derived: npc = num_message_classes*num_resource_classes; num_entries = num_ports*npc
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserting low immediately forces reset state
- upd_valid  input  1  update request this cycle
- upd_op  input  num_ports  one-hot target port
- upd_opc  input  npc  one-hot target packet class
- upd_data  input  width  overwrite value (mode 0) / bits to set (mode 1)
- clr_valid  input  1  clear request; ignored in mode 0
- clr_op  input  num_ports  one-hot clear port
- clr_opc  input  npc  one-hot clear packet class
- clr_data  input  width  bits to clear (mode 1)
- lkp_valid  input  num_lookups  per-channel lookup request
- lkp_sel_mc  input  num_lookups*num_message_classes  per-channel one-hot message class
- lkp_route_op  input  num_lookups*num_ports  per-channel one-hot output port
- lkp_route_orc  input  num_lookups*num_resource_classes  per-channel one-hot resource class
- flags  output  num_lookups*width  registered lookup result per channel
- flags_valid  output  num_lookups  registered copy of lkp_valid
- flags_op_opc  output  num_entries*width  current stored array (registered state, no bypass)
- error  output  1  sticky malformed-select indicator

## Operation
- Entry layout: packet class c = mc*num_resource_classes + rc; entry (p,c) bit b sits at flat index (p*npc + c)*width + b, MSB-first `[0:…]` ordering; channel k occupies slice k of every per-lookup bus.
- Next-state per entry (p,c) with hit_u = upd_valid & upd_op[p] & upd_opc[c], hit_c = clr_valid & clr_op[p] & clr_opc[c]:
  - mode 0: next = hit_u ? upd_data : cur.
  - mode 1: next = (cur & ~(hit_c ? clr_data : 0)) | (hit_u ? upd_data : 0); set wins over clear on the same bit.
- Lookup channel k: entry = (lkp_route_op_k, lkp_sel_mc_k × lkp_route_orc_k); read value is that entry's next-state value (write-first bypass), so an update/clear in the same cycle is visible.
- flags_k registered only when lkp_valid_k = 1; holds previous value otherwise. flags_valid_k <= lkp_valid_k every cycle.
- Select decoding: AND-OR select; a zero select yields 0. Multiple lookups may hit the same entry simultaneously; all receive identical data.
- error sets (and stays set until reset) if, in any cycle, a valid update, valid clear (mode 1 only) or valid lookup has any select vector not exactly one-hot. Invalid requests are never checked. Malformed update/clear still applies to every entry it decodes to (no suppression).

## Timing
- Reset state: every entry = reset_value; flags = 0; flags_valid = 0; error = 0; flags_op_opc = reset_value replicated.
- Lookup latency 1: request at cycle t -> flags/flags_valid at t+1.
- Update at t -> flags_op_opc reflects it at t+1; a same-cycle lookup at t also sees it at t+1.
- Back-to-back lookups every cycle at full rate; no stalls, no backpressure.
- Reset asserted mid-operation: state and outputs return to reset values immediately; the first valid lookup after deassertion returns reset_value (or a same-cycle update).

## Test plan
- Reset defaults, reset_value=1, width=1: lookup port 3, mc 1, rc 0 -> flags=1 next cycle, flags_valid=1, error=0, flags_op_opc all ones.
- Mode 0 overwrite + bypass: width=4, update (p2, c3) data 0xA and lookup same entry in same cycle -> flags=0xA at t+1; neighbour (p2, c2) still 0x0.
- Mode 1 collision: entry holds 0x3, same cycle upd_data 0x4, clr_data 0x5 -> entry 0x6 (bit 2 set wins, bit 0 cleared).
- Dual lookup: channel 0 to (p0, c1), channel 1 to (p4, c2) with distinct stored values 0x1/0x2; lkp_valid=10 -> flags_valid=10, flags0 updated, flags1 holds prior value.
- Error: valid lookup with lkp_route_op=5'b01100 -> error=1 next cycle and stays 1 through later legal traffic; invalid request with bad select -> error stays 0.
- Async reset mid-stream: reset low between edges after several updates -> all outputs revert immediately; flags_op_opc = reset_value replicated.
